// File: rtl/bell_pkg.sv
// Shared definitions for the alarm bell ringer.
//   bellState_t      : ringer FSM states
//   *_DEF constants  : default ring time, snooze time and snooze allowance
//   timerWidth()     : bits needed to hold the longer of the two countdowns
package bell_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2,
    DONE   = 2'd3
  } bellState_t;

  localparam int RING_SECS_DEF   = 60;
  localparam int SNOOZE_SECS_DEF = 300;
  localparam int MAX_SNOOZE_DEF  = 3;

  // ceil(log2(max+1)), never narrower than one bit
  function automatic int timerWidth(input int ringSecs, input int snoozeSecs);
    int longest;
    longest = (ringSecs > snoozeSecs) ? ringSecs : snoozeSecs;
    return (longest < 1) ? 1 : $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/bell_sec_timer.sv
// Loadable seconds down-counter shared by the RING and SNOOZE countdowns.
//   clk     : system clock
//   rst     : synchronous active-high clear (count = 0)
//   load    : load loadVal (wins over dec)
//   loadVal : countdown start value in seconds
//   dec     : one-second decrement request; saturates at zero
//   zero    : count is 0
//   lastSec : count is 1, so the next decrement expires the countdown
module bell_sec_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         dec,
  output logic         zero,
  output logic         lastSec
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero    = (count == '0);
  assign lastSec = (count == W'(1));

endmodule

// File: rtl/bell_ringer.sv
// Alarm bell ringer: starts ringing on a rising alarm match, beats the
// sounder 1 s on / 1 s off, supports a limited number of snoozes and stops
// on StopKey, on ring timeout or when the arm switch is turned off.
//   CP        : system clock (rising edge)
//   CR        : synchronous active-high reset
//   EN        : global enable, low freezes everything and mutes the sounder
//   Tick1Hz   : one-CP pulse per second
//   Match     : alarm time equals current time (level)
//   BellEn    : alarm arm switch
//   SnoozeKey : debounced single-CP snooze request
//   StopKey   : debounced single-CP stop request
//   BellRadio : registered sounder drive
//   Ringing   : high while ringing
//   Snoozed   : high while snoozing
//   SnoozeCnt : snoozes used in the current alarm event
module bell_ringer
  import bell_pkg::*;
#(
  parameter int RING_SECS   = RING_SECS_DEF,
  parameter int SNOOZE_SECS = SNOOZE_SECS_DEF,
  parameter int MAX_SNOOZE  = MAX_SNOOZE_DEF
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       EN,
  input  logic       Tick1Hz,
  input  logic       Match,
  input  logic       BellEn,
  input  logic       SnoozeKey,
  input  logic       StopKey,
  output logic       BellRadio,
  output logic       Ringing,
  output logic       Snoozed,
  output logic [1:0] SnoozeCnt
);

  localparam int            TW           = timerWidth(RING_SECS, SNOOZE_SECS);
  localparam logic [TW-1:0] RING_LOAD    = TW'(RING_SECS);
  localparam logic [TW-1:0] SNOOZE_LOAD  = TW'(SNOOZE_SECS);
  localparam logic [1:0]    SNOOZE_LIMIT = 2'(MAX_SNOOZE);

  bellState_t    state;
  logic          matchQ;
  logic          beat;
  logic [1:0]    snoozeCntQ;
  logic          radioQ;
  logic          ringQ;
  logic          snzQ;

  logic          trigger;
  logic          timerLoad;
  logic [TW-1:0] timerLoadVal;
  logic          timerDec;
  logic          timerZero;
  logic          timerLast;
  logic          secEnd;

  assign trigger = Match & ~matchQ & BellEn;
  // A tick that takes the countdown to zero (or finds it already there)
  assign secEnd  = Tick1Hz & (timerLast | timerZero);

  // Timer control mirrors the FSM decisions below; keys pre-empt ticks.
  always_comb begin
    timerLoad    = 1'b0;
    timerLoadVal = RING_LOAD;
    timerDec     = 1'b0;
    if (EN && BellEn) begin
      case (state)
        IDLE: begin
          timerLoad = trigger;
        end
        RING: begin
          if (!StopKey && SnoozeKey && (snoozeCntQ < SNOOZE_LIMIT)) begin
            timerLoad    = 1'b1;
            timerLoadVal = SNOOZE_LOAD;
          end else if (!StopKey && !SnoozeKey) begin
            timerDec = Tick1Hz;
          end
        end
        SNOOZE: begin
          if (!StopKey) begin
            if (secEnd) begin
              timerLoad = 1'b1;
            end else begin
              timerDec = Tick1Hz;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  bell_sec_timer #(
    .W(TW)
  ) uTimer (
    .clk     (CP),
    .rst     (CR),
    .load    (timerLoad),
    .loadVal (timerLoadVal),
    .dec     (timerDec),
    .zero    (timerZero),
    .lastSec (timerLast)
  );

  always_ff @(posedge CP) begin
    if (CR) begin
      state      <= IDLE;
      matchQ     <= 1'b0;
      beat       <= 1'b0;
      snoozeCntQ <= 2'd0;
      radioQ     <= 1'b0;
      ringQ      <= 1'b0;
      snzQ       <= 1'b0;
    end else if (!EN) begin
      radioQ <= 1'b0;
    end else begin
      matchQ <= Match;
      if (!BellEn) begin
        state      <= IDLE;
        beat       <= 1'b0;
        snoozeCntQ <= 2'd0;
        radioQ     <= 1'b0;
        ringQ      <= 1'b0;
        snzQ       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            snoozeCntQ <= 2'd0;
            if (trigger) begin
              state  <= RING;
              beat   <= 1'b1;
              radioQ <= 1'b1;
              ringQ  <= 1'b1;
            end
          end
          RING: begin
            if (StopKey || (SnoozeKey && (snoozeCntQ >= SNOOZE_LIMIT)) ||
                (!SnoozeKey && secEnd)) begin
              state  <= DONE;
              radioQ <= 1'b0;
              ringQ  <= 1'b0;
              snzQ   <= 1'b0;
            end else if (SnoozeKey) begin
              state      <= SNOOZE;
              snoozeCntQ <= snoozeCntQ + 2'd1;
              radioQ     <= 1'b0;
              ringQ      <= 1'b0;
              snzQ       <= 1'b1;
            end else if (Tick1Hz) begin
              beat   <= ~beat;
              radioQ <= ~beat;
            end else begin
              // re-drives the sounder after an EN-low mute
              radioQ <= beat;
            end
          end
          SNOOZE: begin
            if (StopKey) begin
              state  <= DONE;
              radioQ <= 1'b0;
              ringQ  <= 1'b0;
              snzQ   <= 1'b0;
            end else if (secEnd) begin
              state  <= RING;
              beat   <= 1'b1;
              radioQ <= 1'b1;
              ringQ  <= 1'b1;
              snzQ   <= 1'b0;
            end
          end
          DONE: begin
            if (!Match) begin
              state      <= IDLE;
              snoozeCntQ <= 2'd0;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign BellRadio = radioQ;
  assign Ringing   = ringQ;
  assign Snoozed   = snzQ;
  assign SnoozeCnt = snoozeCntQ;

endmodule

// File: tb/tb_bell_ringer.sv
// Bench for bell_ringer with RING_SECS=4, SNOOZE_SECS=6, MAX_SNOOZE=2.
// The reference model tracks the alarm as a phase plus the number of whole
// seconds spent in the current ring or snooze stretch; the sounder beat is
// the parity of the seconds rung so far.
module tb_bell_ringer;

  localparam int RS = 4;
  localparam int SS = 6;
  localparam int MS = 2;

  localparam int P_IDLE   = 0;
  localparam int P_RING   = 1;
  localparam int P_SNOOZE = 2;
  localparam int P_DONE   = 3;

  logic       CP = 1'b0;
  logic       CR, EN, Tick1Hz, Match, BellEn, SnoozeKey, StopKey;
  logic       BellRadio, Ringing, Snoozed;
  logic [1:0] SnoozeCnt;

  int total  = 0;
  int passed = 0;

  // reference model state
  int mPhase    = P_IDLE;
  int mElapsed  = 0;
  int mSnoozes  = 0;
  bit mPrevMatch = 1'b0;
  bit mRadio    = 1'b0;
  bit armed     = 1'b0;

  bell_ringer #(
    .RING_SECS   (RS),
    .SNOOZE_SECS (SS),
    .MAX_SNOOZE  (MS)
  ) dut (
    .CP        (CP),
    .CR        (CR),
    .EN        (EN),
    .Tick1Hz   (Tick1Hz),
    .Match     (Match),
    .BellEn    (BellEn),
    .SnoozeKey (SnoozeKey),
    .StopKey   (StopKey),
    .BellRadio (BellRadio),
    .Ringing   (Ringing),
    .Snoozed   (Snoozed),
    .SnoozeCnt (SnoozeCnt)
  );

  always #5 CP = ~CP;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // one clock edge of the reference model, using the inputs present at the edge
  task automatic modelStep();
    bit trig;
    if (CR) begin
      mPhase = P_IDLE; mElapsed = 0; mSnoozes = 0; mPrevMatch = 1'b0;
      mRadio = 1'b0; armed = 1'b1;
    end else if (!EN) begin
      mRadio = 1'b0;
    end else begin
      trig = Match && !mPrevMatch && BellEn;
      mPrevMatch = Match;
      if (!BellEn) begin
        mPhase = P_IDLE; mSnoozes = 0;
      end else begin
        case (mPhase)
          P_IDLE: if (trig) begin mPhase = P_RING; mElapsed = 0; end
          P_RING: begin
            if (StopKey) mPhase = P_DONE;
            else if (SnoozeKey) begin
              if (mSnoozes < MS) begin mSnoozes++; mPhase = P_SNOOZE; mElapsed = 0; end
              else mPhase = P_DONE;
            end else if (Tick1Hz) begin
              mElapsed++;
              if (mElapsed >= RS) mPhase = P_DONE;
            end
          end
          P_SNOOZE: begin
            if (StopKey) mPhase = P_DONE;
            else if (Tick1Hz) begin
              mElapsed++;
              if (mElapsed >= SS) begin mPhase = P_RING; mElapsed = 0; end
            end
          end
          default: if (!Match) begin mPhase = P_IDLE; mSnoozes = 0; end
        endcase
      end
      mRadio = (mPhase == P_RING) && (mElapsed % 2 == 0);
    end
  endtask

  // drive pulses for one cycle, advance the model at the edge, settle
  task automatic cyc(input bit tick, input bit snz, input bit stp);
    Tick1Hz = tick; SnoozeKey = snz; StopKey = stp;
    @(posedge CP);
    modelStep();
    #1;
    Tick1Hz = 1'b0; SnoozeKey = 1'b0; StopKey = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
    end
  endtask

  always @(negedge CP) begin
    if (armed) begin
      check("ringing",   {3'b000, Ringing},   {3'b000, mPhase == P_RING});
      check("snoozed",   {3'b000, Snoozed},   {3'b000, mPhase == P_SNOOZE});
      check("bellradio", {3'b000, BellRadio}, {3'b000, mRadio});
      check("snoozecnt", {2'b00, SnoozeCnt},  4'(mSnoozes));
    end
  end

  initial begin
    CR = 1'b1; EN = 1'b1; BellEn = 1'b1; Match = 1'b0;
    Tick1Hz = 1'b0; SnoozeKey = 1'b0; StopKey = 1'b0;

    // reset state
    cyc(0, 0, 0);
    check("rst_radio", {3'b000, BellRadio}, 4'd0);
    check("rst_ring",  {3'b000, Ringing},   4'd0);
    check("rst_snz",   {3'b000, Snoozed},   4'd0);
    check("rst_cnt",   {2'b00, SnoozeCnt},  4'd0);
    CR = 1'b0;
    cyc(0, 0, 0);

    // ring to timeout: beat 1,0,1,0 then done after the 4th tick
    Match = 1'b1;
    cyc(0, 0, 0);
    check("t1_ring",   {3'b000, Ringing},   4'd1);
    check("t1_radio0", {3'b000, BellRadio}, 4'd1);
    check("t1_model",  4'(mPhase), 4'(P_RING));
    cyc(1, 0, 0);
    check("t1_radio1", {3'b000, BellRadio}, 4'd0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    check("t1_radio2", {3'b000, BellRadio}, 4'd1);
    cyc(1, 0, 0);
    check("t1_radio3", {3'b000, BellRadio}, 4'd0);
    check("t1_ring3",  {3'b000, Ringing},   4'd1);
    cyc(1, 0, 0);
    check("t1_done",   {3'b000, Ringing},   4'd0);
    check("t1_mdone",  4'(mPhase), 4'(P_DONE));
    Match = 1'b0;
    cyc(0, 0, 0);

    // snooze twice, third snooze ends the event
    Match = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    check("t2_snz1",  {3'b000, Snoozed},  4'd1);
    check("t2_cnt1",  {2'b00, SnoozeCnt}, 4'd1);
    ticks(5);
    check("t2_still", {3'b000, Snoozed},  4'd1);
    cyc(1, 0, 0);
    check("t2_rering", {3'b000, Ringing},  4'd1);
    check("t2_rradio", {3'b000, BellRadio}, 4'd1);
    cyc(0, 1, 0);
    check("t2_cnt2",  {2'b00, SnoozeCnt}, 4'd2);
    ticks(6);
    check("t2_ring2", {3'b000, Ringing},  4'd1);
    cyc(0, 1, 0);
    check("t2_done",  {3'b000, Ringing},  4'd0);
    check("t2_dsnz",  {3'b000, Snoozed},  4'd0);
    check("t2_dcnt",  {2'b00, SnoozeCnt}, 4'd2);
    Match = 1'b0;
    cyc(0, 0, 0);
    check("t2_clr",   {2'b00, SnoozeCnt}, 4'd0);

    // stop wins over snooze
    Match = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 1, 1);
    check("t3_ring", {3'b000, Ringing},  4'd0);
    check("t3_snz",  {3'b000, Snoozed},  4'd0);
    check("t3_cnt",  {2'b00, SnoozeCnt}, 4'd0);
    Match = 1'b0;
    cyc(0, 0, 0);

    // arm switch off mid-snooze
    Match = 1'b1;
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    BellEn = 1'b0;
    cyc(0, 0, 0);
    check("t4_snz",   {3'b000, Snoozed},   4'd0);
    check("t4_cnt",   {2'b00, SnoozeCnt},  4'd0);
    check("t4_radio", {3'b000, BellRadio}, 4'd0);
    BellEn = 1'b1; Match = 1'b0;
    cyc(0, 0, 0);

    // enable low freezes the ring mid-count
    Match = 1'b1;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    check("t5_pre",   {3'b000, BellRadio}, 4'd1);
    EN = 1'b0;
    ticks(3);
    check("t5_mute",  {3'b000, BellRadio}, 4'd0);
    check("t5_hold",  {3'b000, Ringing},   4'd1);
    EN = 1'b1;
    cyc(0, 0, 0);
    check("t5_resume", {3'b000, BellRadio}, 4'd1);
    cyc(1, 0, 0);
    check("t5_r3",    {3'b000, Ringing},   4'd1);
    cyc(1, 0, 0);
    check("t5_done",  {3'b000, Ringing},   4'd0);
    Match = 1'b0;
    cyc(0, 0, 0);

    // reset mid-ring with Match held high
    Match = 1'b1;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    CR = 1'b1;
    cyc(0, 0, 0);
    check("t6_ring0",  {3'b000, Ringing},   4'd0);
    check("t6_radio0", {3'b000, BellRadio}, 4'd0);
    CR = 1'b0;
    cyc(0, 0, 0);
    check("t6_rering", {3'b000, Ringing},   4'd1);
    cyc(0, 0, 1);
    Match = 1'b0;
    cyc(0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      CR     = ($urandom_range(0, 299) == 0);
      EN     = ($urandom_range(0, 11) != 0);
      BellEn = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 19) == 0) Match = ~Match;
      cyc($urandom_range(0, 4) == 0, $urandom_range(0, 13) == 0,
          $urandom_range(0, 29) == 0);
    end

    @(posedge CP);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
